// File: rtl/xif_result_buffer.sv
`default_nettype none
// ============================================================================
//  Module      : xif_result_buffer
//  Description : In-order result FIFO between the FPU result interface and
//                the core's XIF writeback port. Results whose instruction id
//                has been killed by the core are filtered out on entry.
//
//  Ports
//    ck, rst             clock; synchronous active-high reset
//    in_valid/in_ready   FPU result handshake (in_id, in_data, in_rd)
//    commit_valid        core commit/kill of commit_id (commit_kill = 1: kill)
//    out_valid/out_ready writeback handshake (out_id, out_data, out_rd)
//    count               number of stored entries
//    drop                high in the cycle an incoming result is discarded
//
//  Revision    : 1.0  initial release
// ============================================================================
module xif_result_buffer #(
    parameter int X_ID_WIDTH = 4,
    parameter int XLEN       = 32,
    parameter int DEPTH      = 4    // power of two, >= 2
) (
    input  wire logic                     ck,
    input  wire logic                     rst,
    input  wire logic                     in_valid,
    output logic                          in_ready,
    input  wire logic [X_ID_WIDTH-1:0]    in_id,
    input  wire logic [XLEN-1:0]          in_data,
    input  wire logic [4:0]               in_rd,
    input  wire logic                     commit_valid,
    input  wire logic [X_ID_WIDTH-1:0]    commit_id,
    input  wire logic                     commit_kill,
    output logic                          out_valid,
    input  wire logic                     out_ready,
    output logic [X_ID_WIDTH-1:0]         out_id,
    output logic [XLEN-1:0]               out_data,
    output logic [4:0]                    out_rd,
    output logic [$clog2(DEPTH):0]        count,
    output logic                          drop
);

    localparam int c_PTR_W = $clog2(DEPTH);
    localparam int c_CNT_W = c_PTR_W + 1;
    localparam int c_IDS   = 1 << X_ID_WIDTH;

    logic [XLEN-1:0]        r_data [DEPTH];
    logic [X_ID_WIDTH-1:0]  r_id   [DEPTH];
    logic [4:0]             r_rd   [DEPTH];
    logic [c_PTR_W-1:0]     r_wptr;
    logic [c_PTR_W-1:0]     r_rptr;
    logic [c_CNT_W-1:0]     r_count;
    logic [c_IDS-1:0]       r_kill;

    logic                   w_empty;
    logic                   w_in_hs;
    logic                   w_killed;
    logic                   w_push;
    logic                   w_pop;
    logic                   w_discard;

    // in_ready depends only on the registered count, so a pop in the same
    // cycle never frees a slot combinationally.
    assign in_ready  = (r_count < c_CNT_W'(DEPTH));
    assign w_empty   = (r_count == '0);
    assign out_valid = !w_empty;

    // Inputs presented during a reset cycle are ignored entirely.
    assign w_in_hs   = in_valid && in_ready && !rst;
    // A kill arriving in the same cycle as the result still discards it.
    assign w_killed  = r_kill[in_id]
                     || (commit_valid && commit_kill && (commit_id == in_id));
    assign w_push    = w_in_hs && !w_killed;
    assign w_discard = w_in_hs && w_killed;
    assign w_pop     = out_valid && out_ready && !rst;
    assign drop      = w_discard;

    assign out_id    = w_empty ? '0 : r_id[r_rptr];
    assign out_data  = w_empty ? '0 : r_data[r_rptr];
    assign out_rd    = w_empty ? '0 : r_rd[r_rptr];
    assign count     = r_count;

    // Storage needs no reset: outputs are masked to zero while empty.
    always_ff @(posedge ck) begin
        if (w_push) begin
            r_data[r_wptr] <= in_data;
            r_id[r_wptr]   <= in_id;
            r_rd[r_wptr]   <= in_rd;
        end
    end

    always_ff @(posedge ck) begin
        if (rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= (r_wptr == c_PTR_W'(DEPTH - 1)) ? '0 : r_wptr + c_PTR_W'(1);
            end
            if (w_pop) begin
                r_rptr <= (r_rptr == c_PTR_W'(DEPTH - 1)) ? '0 : r_rptr + c_PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_CNT_W'(1);
                2'b01:   r_count <= r_count - c_CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // The discard clear is written last so it wins when the same cycle's
    // commit kills the very id being discarded; a commit of any other id
    // still takes effect alongside it.
    always_ff @(posedge ck) begin
        if (rst) begin
            r_kill <= '0;
        end else begin
            if (commit_valid) begin
                r_kill[commit_id] <= commit_kill;
            end
            if (w_discard) begin
                r_kill[in_id] <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_xif_result_buffer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_xif_result_buffer
//  Description : Self-checking bench for xif_result_buffer: directed vector
//                table, hand-written multi-cycle sequences and a randomized
//                run compared against a queue-based reference model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_xif_result_buffer;

    localparam int c_IDW   = 4;
    localparam int c_XLEN  = 32;
    localparam int c_DEPTH = 4;
    localparam int c_CW    = $clog2(c_DEPTH) + 1;

    logic              ck = 1'b0;
    logic              rst;
    logic              in_valid;
    logic              in_ready;
    logic [c_IDW-1:0]  in_id;
    logic [c_XLEN-1:0] in_data;
    logic [4:0]        in_rd;
    logic              commit_valid;
    logic [c_IDW-1:0]  commit_id;
    logic              commit_kill;
    logic              out_valid;
    logic              out_ready;
    logic [c_IDW-1:0]  out_id;
    logic [c_XLEN-1:0] out_data;
    logic [4:0]        out_rd;
    logic [c_CW-1:0]   count;
    logic              drop;

    xif_result_buffer #(
        .X_ID_WIDTH (c_IDW),
        .XLEN       (c_XLEN),
        .DEPTH      (c_DEPTH)
    ) u_dut (
        .ck           (ck),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_id        (in_id),
        .in_data      (in_data),
        .in_rd        (in_rd),
        .commit_valid (commit_valid),
        .commit_id    (commit_id),
        .commit_kill  (commit_kill),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_id       (out_id),
        .out_data     (out_data),
        .out_rd       (out_rd),
        .count        (count),
        .drop         (drop)
    );

    always #5 ck = ~ck;

    typedef struct {
        logic              rst;
        logic              iv;
        logic [c_IDW-1:0]  iid;
        logic [c_XLEN-1:0] idata;
        logic [4:0]        ird;
        logic              cv;
        logic [c_IDW-1:0]  cid;
        logic              ckill;
        logic              ordy;
        logic              chk;
        logic [c_CW-1:0]   e_count;
        logic              e_ov;
        logic              e_ir;
        logic              e_drop;
        logic [c_IDW-1:0]  e_id;
        logic [c_XLEN-1:0] e_data;
        logic [4:0]        e_rd;
    } vec_t;

    typedef struct {
        logic [c_IDW-1:0]  id;
        logic [c_XLEN-1:0] data;
        logic [4:0]        rd;
    } ent_t;

    int   errors = 0;
    int   checks = 0;

    // Reference model: queue of stored results plus a per-id kill flag.
    ent_t m_q[$];
    bit   m_kill [1 << c_IDW];
    bit   m_live = 1'b0;
    vec_t cur;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic vec_t stim(input logic r, input logic iv, input int iid,
                                  input logic [31:0] idata, input int ird,
                                  input logic cv, input int cid, input logic ckill,
                                  input logic ordy);
        vec_t v;
        v = '{default: '0};
        v.rst = r; v.iv = iv; v.iid = c_IDW'(iid); v.idata = idata; v.ird = 5'(ird);
        v.cv = cv; v.cid = c_IDW'(cid); v.ckill = ckill; v.ordy = ordy;
        return v;
    endfunction

    function automatic vec_t expect_(input vec_t vi, input int cnt, input logic ov,
                                     input logic ir, input logic dr, input int id,
                                     input logic [31:0] data, input int rd);
        vec_t v;
        v = vi;
        v.chk = 1'b1; v.e_count = c_CW'(cnt); v.e_ov = ov; v.e_ir = ir; v.e_drop = dr;
        v.e_id = c_IDW'(id); v.e_data = data; v.e_rd = 5'(rd);
        return v;
    endfunction

    // Apply inputs, let them settle, compare DUT against the model.
    task automatic drive(input vec_t v);
        ent_t  h;
        bit    accept;
        bit    killed;
        cur          = v;
        rst          = v.rst;
        in_valid     = v.iv;
        in_id        = v.iid;
        in_data      = v.idata;
        in_rd        = v.ird;
        commit_valid = v.cv;
        commit_id    = v.cid;
        commit_kill  = v.ckill;
        out_ready    = v.ordy;
        #4;
        if (m_live) begin
            accept = !v.rst && v.iv && (m_q.size() < c_DEPTH);
            killed = m_kill[v.iid] || (v.cv && v.ckill && v.cid == v.iid);
            check("model.count", 64'(count), 64'(m_q.size()));
            check("model.out_valid", 64'(out_valid), 64'(m_q.size() != 0));
            check("model.in_ready", 64'(in_ready), 64'(m_q.size() < c_DEPTH));
            check("model.drop", 64'(drop), 64'(accept && killed));
            if (m_q.size() != 0) h = m_q[0];
            else h = '{id: '0, data: '0, rd: '0};
            check("model.out_id", 64'(out_id), 64'(h.id));
            check("model.out_data", 64'(out_data), 64'(h.data));
            check("model.out_rd", 64'(out_rd), 64'(h.rd));
        end
    endtask

    // Advance one clock edge and step the model with the applied inputs.
    task automatic clock_edge();
        bit accept;
        bit killed;
        bit pop;
        @(posedge ck);
        if (cur.rst) begin
            m_q.delete();
            foreach (m_kill[i]) m_kill[i] = 1'b0;
            m_live = 1'b1;
        end else begin
            accept = cur.iv && (m_q.size() < c_DEPTH);
            killed = m_kill[cur.iid] || (cur.cv && cur.ckill && cur.cid == cur.iid);
            pop    = (m_q.size() != 0) && cur.ordy;
            if (pop) void'(m_q.pop_front());
            if (accept && !killed) m_q.push_back('{id: cur.iid, data: cur.idata, rd: cur.ird});
            if (cur.cv) m_kill[cur.cid] = cur.ckill;
            if (accept && killed) m_kill[cur.iid] = 1'b0;
        end
        #1;
    endtask

    task automatic cycle(input vec_t v);
        drive(v);
        if (v.chk) begin
            check("tbl.count", 64'(count), 64'(v.e_count));
            check("tbl.out_valid", 64'(out_valid), 64'(v.e_ov));
            check("tbl.in_ready", 64'(in_ready), 64'(v.e_ir));
            check("tbl.drop", 64'(drop), 64'(v.e_drop));
            check("tbl.out_id", 64'(out_id), 64'(v.e_id));
            check("tbl.out_data", 64'(out_data), 64'(v.e_data));
            check("tbl.out_rd", 64'(out_rd), 64'(v.e_rd));
        end
        clock_edge();
    endtask

    function automatic vec_t idle(input logic ordy);
        return stim(0, 0, 0, 0, 0, 0, 0, 0, ordy);
    endfunction

    function automatic vec_t push(input int id, input logic ordy);
        return stim(0, 1, id, 32'h100 + 32'(id), id % 32, 0, 0, 0, ordy);
    endfunction

    vec_t tbl [23];

    initial begin
        // Expectations are what the outputs show while the row's inputs are applied.
        tbl[0]  = stim(1, 0, 0, 0, 0, 0, 0, 0, 0);
        tbl[1]  = expect_(stim(0, 1, 3, 32'h3F800000, 5, 0, 0, 0, 1), 0, 0, 1, 0, 0, 0, 0);
        tbl[2]  = expect_(idle(1), 1, 1, 1, 0, 3, 32'h3F800000, 5);
        tbl[3]  = expect_(idle(0), 0, 0, 1, 0, 0, 0, 0);
        tbl[4]  = expect_(stim(0, 0, 0, 0, 0, 1, 7, 1, 0), 0, 0, 1, 0, 0, 0, 0);
        tbl[5]  = expect_(stim(0, 1, 7, 32'h11, 1, 0, 0, 0, 0), 0, 0, 1, 1, 0, 0, 0);
        tbl[6]  = expect_(stim(0, 1, 7, 32'h22, 2, 0, 0, 0, 0), 0, 0, 1, 0, 0, 0, 0);
        tbl[7]  = expect_(idle(0), 1, 1, 1, 0, 7, 32'h22, 2);
        tbl[8]  = expect_(idle(1), 1, 1, 1, 0, 7, 32'h22, 2);
        tbl[9]  = expect_(idle(0), 0, 0, 1, 0, 0, 0, 0);
        tbl[10] = expect_(stim(0, 1, 2, 32'h33, 3, 1, 2, 1, 0), 0, 0, 1, 1, 0, 0, 0);
        tbl[11] = expect_(stim(0, 1, 2, 32'h44, 3, 0, 0, 0, 0), 0, 0, 1, 0, 0, 0, 0);
        tbl[12] = expect_(idle(1), 1, 1, 1, 0, 2, 32'h44, 3);
        tbl[13] = expect_(idle(0), 0, 0, 1, 0, 0, 0, 0);
        tbl[14] = expect_(stim(0, 0, 0, 0, 0, 1, 9, 1, 0), 0, 0, 1, 0, 0, 0, 0);
        tbl[15] = expect_(stim(0, 1, 9, 32'h55, 4, 1, 4, 1, 0), 0, 0, 1, 1, 0, 0, 0);
        tbl[16] = expect_(stim(0, 1, 4, 32'h66, 4, 0, 0, 0, 0), 0, 0, 1, 1, 0, 0, 0);
        tbl[17] = expect_(idle(0), 0, 0, 1, 0, 0, 0, 0);
        tbl[18] = expect_(stim(0, 0, 0, 0, 0, 1, 6, 1, 0), 0, 0, 1, 0, 0, 0, 0);
        tbl[19] = expect_(stim(0, 0, 0, 0, 0, 1, 6, 0, 0), 0, 0, 1, 0, 0, 0, 0);
        tbl[20] = expect_(stim(0, 1, 6, 32'h77, 7, 0, 0, 0, 0), 0, 0, 1, 0, 0, 0, 0);
        tbl[21] = expect_(idle(1), 1, 1, 1, 0, 6, 32'h77, 7);
        tbl[22] = expect_(idle(0), 0, 0, 1, 0, 0, 0, 0);

        for (int i = 0; i < 23; i++) cycle(tbl[i]);

        // Fill and backpressure: fifth push must be refused.
        for (int i = 0; i < 5; i++) begin
            drive(push(i, 0));
            if (i == 4) begin
                check("fill.count", 64'(count), 64'(4));
                check("fill.in_ready", 64'(in_ready), 64'(0));
            end
            clock_edge();
        end
        // Full with out_ready=1 still refuses the push; slot frees next cycle.
        for (int i = 0; i < 4; i++) begin
            drive(i == 0 ? push(9, 1) : idle(1));
            check("drain.out_id", 64'(out_id), 64'(i));
            if (i == 0) check("drain.full_in_ready", 64'(in_ready), 64'(0));
            if (i == 1) check("drain.in_ready", 64'(in_ready), 64'(1));
            clock_edge();
        end
        drive(idle(0));
        check("drain.empty", 64'(out_valid), 64'(0));
        clock_edge();

        // Concurrent push/pop at count=2 across pointer wrap.
        cycle(push(0, 0));
        cycle(push(1, 0));
        for (int k = 0; k < 10; k++) begin
            drive(push(k + 2, 1));
            check("conc.count", 64'(count), 64'(2));
            check("conc.out_id", 64'(out_id), 64'(k));
            clock_edge();
        end
        cycle(idle(1));
        cycle(idle(1));

        // Reset mid-operation with stored entries and a kill bit set.
        cycle(push(10, 0));
        cycle(push(11, 0));
        cycle(stim(0, 1, 12, 32'h12, 12, 1, 5, 1, 0));
        drive(stim(1, 1, 13, 32'h13, 13, 1, 3, 1, 1));
        check("rst.pre_count", 64'(count), 64'(3));
        clock_edge();
        drive(idle(0));
        check("rst.count", 64'(count), 64'(0));
        check("rst.out_valid", 64'(out_valid), 64'(0));
        check("rst.in_ready", 64'(in_ready), 64'(1));
        clock_edge();
        drive(push(5, 0));
        check("rst.drop5", 64'(drop), 64'(0));
        clock_edge();
        drive(idle(1));
        check("rst.stored5", 64'(out_id), 64'(5));
        check("rst.count1", 64'(count), 64'(1));
        clock_edge();

        // Randomized traffic against the reference model.
        for (int n = 0; n < 600; n++) begin
            vec_t v;
            v = stim(($urandom % 64) == 0, ($urandom % 3) != 0, $urandom % 8,
                     $urandom, $urandom % 32, ($urandom % 4) == 0, $urandom % 8,
                     $urandom % 2, ($urandom % 3) != 0);
            cycle(v);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Guard against a stuck run.
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, checks=%0d", checks);
        $fatal(1);
    end

endmodule
`default_nettype wire
